icb_arbt: RTL
=============

Name: icb_arbt

Overview:
- N-master to 1-slave ICB arbiter, 16-bit address, 8-bit data.
- Sits directly upstream of the ICB splitter and merges requesters (e.g. frame processor, PDI host) onto one ICB bus.
- Round-robin grant with a lock that holds a stalled command.
- In-order response routing back to the issuing master via a response-ID FIFO.

Parameters:
- ARBT_NUM, 2, number of upstream masters (2..8).
- FIFO_DP, 2, response-ID FIFO depth (1..4); also the maximum number of outstanding commands.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- i_bus_icb_cmd_valid  in  ARBT_NUM  per-master command valid.
- i_bus_icb_cmd_ready  out  ARBT_NUM  per-master command ready.
- i_bus_icb_cmd_read  in  ARBT_NUM  per-master read (1) / write (0).
- i_bus_icb_cmd_addr  in  ARBT_NUM*16  packed addresses; master k at [k*16+15:k*16].
- i_bus_icb_cmd_wdata  in  ARBT_NUM*8  packed write data.
- i_bus_icb_rsp_valid  out  ARBT_NUM  per-master response valid.
- i_bus_icb_rsp_ready  in  ARBT_NUM  per-master response ready.
- i_bus_icb_rsp_err  out  ARBT_NUM  error, replicated to all masters.
- i_bus_icb_rsp_rdata  out  ARBT_NUM*8  rdata, replicated to all masters.
- o_icb_cmd_valid  out  1  merged command valid.
- o_icb_cmd_ready  in  1  merged command ready.
- o_icb_cmd_read  out  1  merged read/write.
- o_icb_cmd_addr  out  16  merged address.
- o_icb_cmd_wdata  out  8  merged write data.
- o_icb_rsp_valid  in  1  merged response valid.
- o_icb_rsp_ready  out  1  merged response ready.
- o_icb_rsp_err  in  1  merged response error.
- o_icb_rsp_rdata  in  8  merged response read data.

Behaviour:
- State: `last_gnt` (one-hot), `lock` (1 bit), response-ID FIFO of FIFO_DP one-hot entries.
- Reset values: `last_gnt` = bit ARBT_NUM-1 (so master 0 wins first), `lock` = 0, FIFO empty.
  - All outputs are combinational from state and inputs; with all input valids at 0 after reset, every valid and ready output is 0.
- Grant, when `lock` = 0: first requesting master found scanning upward from `last_gnt`+1, wrapping modulo ARBT_NUM. No requesters gives gnt = 0.
- Grant, when `lock` = 1: gnt = `last_gnt`.
- Command path:
  - o_icb_cmd_valid = |(gnt & i_bus_icb_cmd_valid) & ~fifo_full.
  - read/addr/wdata are muxed from the granted master; all zero when gnt = 0.
  - i_bus_icb_cmd_ready[k] = gnt[k] & o_icb_cmd_ready & ~fifo_full.
- Lock and pointer update:
  - `lock` <= o_icb_cmd_valid & ~o_icb_cmd_ready, so a presented command is never switched away from.
  - On a command handshake: `last_gnt` <= gnt and `lock` <= 0.
  - If `lock` = 1 and the locked master drops valid (protocol violation), the grant still holds; no handshake occurs.
- FIFO push: gnt is pushed on a command handshake.
- FIFO full: o_icb_cmd_valid and all cmd_ready are forced to 0.
- FIFO pop: on an o-side response handshake.
- Response path:
  - i_bus_icb_rsp_valid[k] = head[k] & o_icb_rsp_valid & ~fifo_empty.
  - o_icb_rsp_ready = |(head & i_bus_icb_rsp_ready) & ~fifo_empty.
- FIFO empty: o_icb_rsp_ready = 0 and all i_bus rsp_valid = 0.
  - A spurious slave response is stalled, never dropped.
  - A same-cycle slave response to a just-issued command is accepted in the next cycle earliest (no bypass).
- Push and pop in the same cycle: both occur and the occupancy is unchanged.
  - When full, the push is already blocked, so a pop frees one slot visible the next cycle.
- Reset mid-transaction: FIFO is flushed and outstanding responses are no longer routed. System reset must cover the slave as well.

Optional Feature:
- Macro ICB_ARBT_FIXED_PRIO_EN.
- Defined: fixed priority with lowest index winning; `last_gnt` is used only for the lock and is not used for grant rotation.
- Undefined: round-robin as specified above.
- The lock and FIFO behaviour are identical in both cases.

Decomposition:
- Shared package `icb_pkg` holds the constants ICB_AW = 16 and ICB_DW = 8, and a one-hot-to-index function.
- Sub-module `icb_rspid_fifo` is a synchronous FIFO:
  - parameters DP and DW; ports clk, rst, i_vld/i_rdy/i_dat, o_vld/o_rdy/o_dat;
  - registered read data, no bypass; i_rdy = ~full, o_vld = ~empty.
- The arbiter core, muxes and response routing stay in `icb_arbt`.

Test Plan:
1. After reset, masters 0 and 1 request simultaneously with o_icb_cmd_ready = 1 → master 0 is granted first, master 1 on the following cycle, then master 0 again (round-robin alternation).
2. Master 1 issues a write to addr 0x0120, wdata 0x5A, while o_icb_cmd_ready is held at 0 for 3 cycles and master 0 raises valid during the stall → grant stays on master 1 (lock) and o_icb_cmd_addr stays at 0x0120; handshake on cycle 4, then master 0 is granted.
3. FIFO_DP = 2: three reads are issued with no responses → the third is blocked (o_icb_cmd_valid = 0) until one response handshakes, and is accepted the cycle after the pop.
4. Master 0 read then master 1 read, slave returns rdata 0x11 then 0x22 with err = 1 on the second → master 0 receives 0x11/err 0, master 1 receives 0x22/err 1, in order.
5. o_icb_rsp_valid = 1 with the FIFO empty → o_icb_rsp_ready = 0 and no i_bus rsp_valid asserted. Separately, master 1 rsp_ready = 0 at the FIFO head → o_icb_rsp_ready = 0 until master 1 is ready.
6. rst asserted asynchronously mid-burst with 2 outstanding entries → FIFO empty and all valid outputs 0 immediately; master 0 is granted first after rst deasserts.

Source files
------------

// File: rtl/icb_pkg.sv
// Shared ICB definitions used by the arbiter and its response-ID FIFO.
//   ICB_AW     : command address width
//   ICB_DW     : command/response data width
//   onehot2idx : binary index of the set bit in a one-hot vector (up to 8 bits)
package icb_pkg;

    localparam int unsigned ICB_AW = 16;
    localparam int unsigned ICB_DW = 8;

    function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/icb_rspid_fifo.sv
// Synchronous FIFO holding the one-hot ID of the master owed each response.
// Read data comes straight from storage registers; a push is visible at the
// output no earlier than the following cycle (no bypass).
//   clk, rst : clock, asynchronous active-high reset (flushes the FIFO)
//   i_vld    : push request          i_rdy : not full
//   i_dat    : pushed entry (DW)
//   o_vld    : not empty             o_rdy : pop request
//   o_dat    : head entry (DW)
// Parameters: DP depth (1..4), DW entry width.
module icb_rspid_fifo #(
    parameter int unsigned DP = 2,
    parameter int unsigned DW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat
);

    // Storage is sized for the maximum depth so the 2-bit pointers index it
    // exactly; only the first DP slots are ever written.
    logic [DW-1:0] mem [4];
    logic [1:0]    rptr;
    logic [1:0]    wptr;
    logic [2:0]    cnt;
    logic          push;
    logic          pop;

    function automatic logic [1:0] ptr_nxt(input logic [1:0] p);
        return (p == 2'(DP - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign i_rdy = (cnt != 3'(DP));
    assign o_vld = (cnt != 3'd0);
    assign push  = i_vld & i_rdy;
    assign pop   = o_rdy & o_vld;
    assign o_dat = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
            for (int unsigned i = 0; i < 4; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= i_dat;
                wptr      <= ptr_nxt(wptr);
            end
            if (pop) rptr <= ptr_nxt(rptr);
            cnt <= cnt + {2'b00, push} - {2'b00, pop};
        end
    end

endmodule

// File: rtl/icb_arbt.sv
// N-master to 1-slave ICB arbiter (16-bit address, 8-bit data).
// Round-robin grant (master 0 first after reset); a presented but stalled
// command locks the grant until it handshakes. Responses return in order to
// the issuing master using a response-ID FIFO, which also bounds the number
// of outstanding commands to FIFO_DP.
// Build option: define ICB_ARBT_FIXED_PRIO_EN for fixed priority (lowest
// index wins) instead of round-robin; lock and FIFO behaviour are unchanged.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   i_bus_icb_cmd_*       : per-master command channels (packed, master k
//                           at [k*W +: W])
//   i_bus_icb_rsp_*       : per-master response channels; err/rdata are
//                           replicated to every master
//   o_icb_cmd_*           : merged command toward the slave
//   o_icb_rsp_*           : merged response from the slave
module icb_arbt
    import icb_pkg::*;
#(
    parameter int unsigned ARBT_NUM = 2,
    parameter int unsigned FIFO_DP  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ARBT_NUM-1:0]        i_bus_icb_cmd_valid,
    output logic [ARBT_NUM-1:0]        i_bus_icb_cmd_ready,
    input  logic [ARBT_NUM-1:0]        i_bus_icb_cmd_read,
    input  logic [ARBT_NUM*ICB_AW-1:0] i_bus_icb_cmd_addr,
    input  logic [ARBT_NUM*ICB_DW-1:0] i_bus_icb_cmd_wdata,
    output logic [ARBT_NUM-1:0]        i_bus_icb_rsp_valid,
    input  logic [ARBT_NUM-1:0]        i_bus_icb_rsp_ready,
    output logic [ARBT_NUM-1:0]        i_bus_icb_rsp_err,
    output logic [ARBT_NUM*ICB_DW-1:0] i_bus_icb_rsp_rdata,
    output logic                       o_icb_cmd_valid,
    input  logic                       o_icb_cmd_ready,
    output logic                       o_icb_cmd_read,
    output logic [ICB_AW-1:0]          o_icb_cmd_addr,
    output logic [ICB_DW-1:0]          o_icb_cmd_wdata,
    input  logic                       o_icb_rsp_valid,
    output logic                       o_icb_rsp_ready,
    input  logic                       o_icb_rsp_err,
    input  logic [ICB_DW-1:0]          o_icb_rsp_rdata
);

    localparam logic [ARBT_NUM-1:0] LAST_GNT_RST = {1'b1, {(ARBT_NUM-1){1'b0}}};

    logic [ARBT_NUM-1:0] last_gnt;
    logic                lock;
    logic [ARBT_NUM-1:0] gnt;
    logic [ARBT_NUM-1:0] head;
    logic                fifo_i_rdy;
    logic                fifo_o_vld;
    logic                fifo_full;
    logic                fifo_empty;
    logic                cmd_hsk;
    logic                rsp_hsk;

    assign fifo_full  = ~fifo_i_rdy;
    assign fifo_empty = ~fifo_o_vld;

    // ------------------------------------------------------------------
    // Grant
    // ------------------------------------------------------------------
`ifdef ICB_ARBT_FIXED_PRIO_EN
    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        if (lock) begin
            gnt = last_gnt;
        end else begin
            for (int unsigned i = 0; i < ARBT_NUM; i++) begin
                if (i_bus_icb_cmd_valid[i] && !found) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end
`else
    // Round-robin without variable indexing: requesters above the last
    // grant take precedence; if none, the lowest requester wraps around.
    always_comb begin
        logic [2:0]          start;
        logic [ARBT_NUM-1:0] req_hi;
        logic [ARBT_NUM-1:0] pick;
        logic                found;
        gnt    = '0;
        found  = 1'b0;
        start  = onehot2idx(8'(last_gnt));
        req_hi = '0;
        for (int unsigned i = 0; i < ARBT_NUM; i++) begin
            req_hi[i] = i_bus_icb_cmd_valid[i] & (3'(i) > start);
        end
        pick = (|req_hi) ? req_hi : i_bus_icb_cmd_valid;
        if (lock) begin
            gnt = last_gnt;
        end else begin
            for (int unsigned i = 0; i < ARBT_NUM; i++) begin
                if (pick[i] && !found) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Command path
    // ------------------------------------------------------------------
    assign o_icb_cmd_valid     = (|(gnt & i_bus_icb_cmd_valid)) & ~fifo_full;
    assign i_bus_icb_cmd_ready = gnt & {ARBT_NUM{o_icb_cmd_ready & ~fifo_full}};
    assign cmd_hsk             = o_icb_cmd_valid & o_icb_cmd_ready;

    // gnt is one-hot or zero, so an AND-OR mux yields zeros when idle.
    always_comb begin
        o_icb_cmd_read  = 1'b0;
        o_icb_cmd_addr  = '0;
        o_icb_cmd_wdata = '0;
        for (int unsigned i = 0; i < ARBT_NUM; i++) begin
            if (gnt[i]) begin
                o_icb_cmd_read  = o_icb_cmd_read  | i_bus_icb_cmd_read[i];
                o_icb_cmd_addr  = o_icb_cmd_addr  | i_bus_icb_cmd_addr[i*ICB_AW +: ICB_AW];
                o_icb_cmd_wdata = o_icb_cmd_wdata | i_bus_icb_cmd_wdata[i*ICB_DW +: ICB_DW];
            end
        end
    end

    // Recording gnt whenever a command is presented keeps last_gnt pointing
    // at the locked master during a stall. With valid dropped while locked,
    // nothing is presented, so the lock and grant simply hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= LAST_GNT_RST;
            lock     <= 1'b0;
        end else if (o_icb_cmd_valid) begin
            last_gnt <= gnt;
            lock     <= ~o_icb_cmd_ready;
        end
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    icb_rspid_fifo #(
        .DP (FIFO_DP),
        .DW (ARBT_NUM)
    ) u_rspid_fifo (
        .clk   (clk),
        .rst   (rst),
        .i_vld (cmd_hsk),
        .i_rdy (fifo_i_rdy),
        .i_dat (gnt),
        .o_vld (fifo_o_vld),
        .o_rdy (rsp_hsk),
        .o_dat (head)
    );

    assign i_bus_icb_rsp_valid = head & {ARBT_NUM{o_icb_rsp_valid & ~fifo_empty}};
    assign o_icb_rsp_ready     = (|(head & i_bus_icb_rsp_ready)) & ~fifo_empty;
    assign rsp_hsk             = o_icb_rsp_valid & o_icb_rsp_ready;
    assign i_bus_icb_rsp_err   = {ARBT_NUM{o_icb_rsp_err}};
    assign i_bus_icb_rsp_rdata = {ARBT_NUM{o_icb_rsp_rdata}};

endmodule
